prga_enc: RTL and testbench
===========================

PRGA_ENC -- requirements
Module: prga_enc

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 en  in  1  start request; sampled only while rdy=1.
REQ-004 rdy  out  1  1 = idle and able to accept en.
REQ-005 s_addr / s_rddata / s_wrdata  out/in/out  8 each  S-box memory port (256x8, single-port).
REQ-006 s_wren  out  1  S-box write enable.
REQ-007 pt_addr / pt_rddata  out/in  8 each  plaintext memory read port; byte 0 = length L, bytes 1..L = message.
REQ-008 ct_addr / ct_wrdata  out/out  8 each  ciphertext memory write port; same length-prefixed layout.
REQ-009 ct_wren  out  1  ciphertext write enable.
REQ-010 All memories: address registered on clk edge N; rddata valid during cycle after edge N.

Function
REQ-011 Block SHALL encrypt with ARC4 PRGA using a pre-scheduled S in s_mem: per k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; ct[k]=pt[k] XOR S[S[i]+S[j]]; all sums mod 256 (8-bit wrap).
REQ-012 i, j SHALL be 0 at job start; ct[0] SHALL be written with L.
REQ-013 Handshake: en=1 at an edge with rdy=1 starts a job; rdy SHALL be 0 from the next cycle until completion; en while rdy=0 SHALL be ignored.
REQ-014 FSM states and per-state actions:
- IDLE: rdy=1; on en -> LEN_A.
- LEN_A: pt_addr=0 -> LEN_D.
- LEN_D: latch L; ct_addr=0, ct_wrdata=L, ct_wren=1; k=1; L=0 -> DONE, else SI_A.
- SI_A: s_addr=i+1; i<=i+1 -> SI_D.
- SI_D: latch si; j<=j+si -> SJ_A.
- SJ_A: s_addr=j -> SJ_D.
- SJ_D: latch sj; s_addr=i, s_wrdata=sj, s_wren=1 -> WJ.
- WJ: s_addr=j, s_wrdata=si, s_wren=1; pt_addr=k -> PAD_A.
- PAD_A: s_addr=si+sj; latch pt_rddata -> PAD_D.
- PAD_D: ct_addr=k, ct_wrdata=s_rddata XOR latched pt, ct_wren=1; k=L -> DONE, else k<=k+1, SI_A.
- DONE: -> IDLE.
REQ-015 Latency: rdy SHALL return high exactly 3+7L rising edges after the en-accepting edge (L=0 -> 3).
REQ-016 s_wren, ct_wren SHALL be 0 in every state not listed as asserting them; never both S writes in one cycle.
REQ-017 When i=j, the two writes SHALL both occur (second overwrites with same value); result equals no swap.
REQ-018 L=255 SHALL complete with k reaching 255 without wrap; i wraps 255->0 normally.
REQ-019 Outputs not named in a state SHALL hold previous values (no X).

Reset
REQ-020 rst_n=0 at any edge, including mid-job, SHALL force IDLE, rdy=1, i=j=k=0, s_wren=0, ct_wren=0, all addresses/wrdata 0.
REQ-021 Memory contents are not restored by reset; partial ct/S writes remain.
REQ-022 en asserted during reset SHALL be ignored; first acceptance is at the first edge with rst_n=1.

Configuration
REQ-023 Macro PRGA_ENC_BYTECOUNT_EN defined: extra output byte_cnt[7:0], reset 0, cleared on job start, incremented on each PAD_D ct write; equals L after completion until next start.
REQ-024 PRGA_ENC_BYTECOUNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-025 S=identity, pt={01,41} -> ct={01,43}; rdy high 10 edges after start.
REQ-026 S=identity, pt={02,41,42} -> ct={02,43,47}; S[2]=03, S[3]=02 afterwards; latency 17.
REQ-027 pt[0]=00 -> only ct[0]=00 written, S untouched, rdy after 3 edges.
REQ-028 Encrypt 5-byte message with S from key 000018, then run prga on ct with same initial S -> pt recovered byte-exact.
REQ-029 rst_n=0 mid-job (after 2nd byte) -> next edge rdy=1, wren=0; fresh job on identity S matches REQ-025.
REQ-030 en held high through whole job -> exactly one job; second job starts on the edge rdy is first seen high.

Source files
------------

// File: rtl/prga_enc_if.sv
// Handshake and memory-port bundle for prga_enc (S-box, plaintext, ciphertext).
// byte_cnt exists only when PRGA_ENC_BYTECOUNT_EN is defined.
interface prga_enc_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;
`ifdef PRGA_ENC_BYTECOUNT_EN
  logic [7:0] byte_cnt;
`endif

  // master: the encryptor, which drives all three memory ports
  modport master (
`ifdef PRGA_ENC_BYTECOUNT_EN
    output byte_cnt,
`endif
    input  en, s_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

  modport slave (
`ifdef PRGA_ENC_BYTECOUNT_EN
    input  byte_cnt,
`endif
    output en, s_rddata, pt_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
endinterface

// File: rtl/prga_enc.sv
// ARC4 PRGA encryptor: walks a length-prefixed plaintext, swaps S in place, writes ciphertext.
// Define PRGA_ENC_BYTECOUNT_EN to add the byte_cnt output.
module prga_enc (
  input  logic       clk,
  input  logic       rst_n,
  prga_enc_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_A, LEN_D, SI_A, SI_D, SJ_A, SJ_D, WJ, PAD_A, PAD_D, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i_q, i_nxt, j_q, j_nxt, k_q, k_nxt, len_q, len_nxt;
  logic [7:0] si_q, si_nxt, sj_q, sj_nxt, ptb_q, ptb_nxt;

  // Addresses and write data are held from the last state that drove them
  logic [7:0] s_addr_q, s_addr_c, s_wrdata_q, s_wrdata_c;
  logic [7:0] pt_addr_q, pt_addr_c, ct_addr_q, ct_addr_c, ct_wrdata_q, ct_wrdata_c;
  logic       s_wren_c, ct_wren_c, rdy_c;
`ifdef PRGA_ENC_BYTECOUNT_EN
  logic [7:0] cnt_q, cnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      ptb_q       <= 8'd0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
`ifdef PRGA_ENC_BYTECOUNT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state       <= state_nxt;
      i_q         <= i_nxt;
      j_q         <= j_nxt;
      k_q         <= k_nxt;
      len_q       <= len_nxt;
      si_q        <= si_nxt;
      sj_q        <= sj_nxt;
      ptb_q       <= ptb_nxt;
      s_addr_q    <= s_addr_c;
      s_wrdata_q  <= s_wrdata_c;
      pt_addr_q   <= pt_addr_c;
      ct_addr_q   <= ct_addr_c;
      ct_wrdata_q <= ct_wrdata_c;
`ifdef PRGA_ENC_BYTECOUNT_EN
      cnt_q       <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    i_nxt       = i_q;
    j_nxt       = j_q;
    k_nxt       = k_q;
    len_nxt     = len_q;
    si_nxt      = si_q;
    sj_nxt      = sj_q;
    ptb_nxt     = ptb_q;
    s_addr_c    = s_addr_q;
    s_wrdata_c  = s_wrdata_q;
    pt_addr_c   = pt_addr_q;
    ct_addr_c   = ct_addr_q;
    ct_wrdata_c = ct_wrdata_q;
    s_wren_c    = 1'b0;
    ct_wren_c   = 1'b0;
    rdy_c       = 1'b0;
`ifdef PRGA_ENC_BYTECOUNT_EN
    cnt_nxt     = cnt_q;
`endif
    case (state)
      IDLE: begin
        rdy_c = 1'b1;
        if (bus.en) begin
          state_nxt = LEN_A;
          i_nxt     = 8'd0;
          j_nxt     = 8'd0;
          k_nxt     = 8'd0;
`ifdef PRGA_ENC_BYTECOUNT_EN
          cnt_nxt   = 8'd0;
`endif
        end
      end
      LEN_A: begin
        pt_addr_c = 8'd0;
        state_nxt = LEN_D;
      end
      LEN_D: begin
        len_nxt     = bus.pt_rddata;
        ct_addr_c   = 8'd0;
        ct_wrdata_c = bus.pt_rddata;
        ct_wren_c   = 1'b1;
        k_nxt       = 8'd1;
        state_nxt   = (bus.pt_rddata == 8'd0) ? DONE : SI_A;
      end
      SI_A: begin
        s_addr_c  = i_q + 8'd1;
        i_nxt     = i_q + 8'd1;
        state_nxt = SI_D;
      end
      SI_D: begin
        si_nxt    = bus.s_rddata;
        j_nxt     = j_q + bus.s_rddata;
        state_nxt = SJ_A;
      end
      SJ_A: begin
        s_addr_c  = j_q;
        state_nxt = SJ_D;
      end
      SJ_D: begin
        sj_nxt     = bus.s_rddata;
        s_addr_c   = i_q;
        s_wrdata_c = bus.s_rddata;
        s_wren_c   = 1'b1;
        state_nxt  = WJ;
      end
      // Second half of the swap; when i==j this rewrites the same value
      WJ: begin
        s_addr_c   = j_q;
        s_wrdata_c = si_q;
        s_wren_c   = 1'b1;
        pt_addr_c  = k_q;
        state_nxt  = PAD_A;
      end
      PAD_A: begin
        s_addr_c  = si_q + sj_q;
        ptb_nxt   = bus.pt_rddata;
        state_nxt = PAD_D;
      end
      PAD_D: begin
        ct_addr_c   = k_q;
        ct_wrdata_c = bus.s_rddata ^ ptb_q;
        ct_wren_c   = 1'b1;
`ifdef PRGA_ENC_BYTECOUNT_EN
        cnt_nxt     = cnt_q + 8'd1;
`endif
        // Compare before incrementing so L=255 finishes without k wrapping
        if (k_q == len_q) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k_q + 8'd1;
          state_nxt = SI_A;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rdy       = rdy_c;
  assign bus.s_addr    = s_addr_c;
  assign bus.s_wrdata  = s_wrdata_c;
  assign bus.s_wren    = s_wren_c;
  assign bus.pt_addr   = pt_addr_c;
  assign bus.ct_addr   = ct_addr_c;
  assign bus.ct_wrdata = ct_wrdata_c;
  assign bus.ct_wren   = ct_wren_c;
`ifdef PRGA_ENC_BYTECOUNT_EN
  assign bus.byte_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_prga_enc.sv
// Scoreboard bench for prga_enc: memory models, reference ARC4 PRGA, latency and reset checks.
module tb_prga_enc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prga_enc_if bus();
  prga_enc u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0]  s_mem [256];
  logic [7:0]  s_img [256];
  logic [7:0]  ref_s [256];
  logic [7:0]  pt_mem[256];
  logic [7:0]  ct_mem[256];
  logic [7:0]  msg   [6];
  logic        ld_s = 1'b0;
  logic [15:0] sb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // Registered-address memories: rddata valid the cycle after the address edge
  always @(posedge clk) begin
    if (ld_s) s_mem <= s_img;
    else if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ct_wren === 1'b1) begin
      chk("ct_avail", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) chk("ct_write", {bus.ct_addr, bus.ct_wrdata}, sb.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void push_expected();
    logic [7:0] ii, jj, t, idx;
    int len;
    ii = 8'd0; jj = 8'd0;
    len = int'(pt_mem[0]);
    sb.push_back({8'h00, pt_mem[0]});
    for (int k = 1; k <= len; k++) begin
      ii = ii + 8'd1;
      jj = jj + ref_s[ii];
      t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
      idx = ref_s[ii] + ref_s[jj];
      sb.push_back({k[7:0], pt_mem[k] ^ ref_s[idx]});
    end
  endfunction

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_img[a] = a[7:0];
  endtask

  task automatic set_ksa();
    logic [7:0] key[3];
    logic [7:0] jj, t;
    key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
    set_identity();
    jj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      jj = jj + s_img[a] + key[a % 3];
      t = s_img[a]; s_img[a] = s_img[jj]; s_img[jj] = t;
    end
  endtask

  task automatic load_s();
    @(negedge clk); ld_s = 1'b1;
    @(posedge clk); #1 ld_s = 1'b0;
    ref_s = s_img;
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); n++;
      #1;
      if (bus.rdy === 1'b1) break;
    end
    chk("latency", n, exp_lat);
  endtask

  task automatic post_job(input logic [7:0] len);
    int d;
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    d = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== ref_s[a]) d++;
    chk("s_state", d, 0);
`ifdef PRGA_ENC_BYTECOUNT_EN
    chk("byte_cnt", bus.byte_cnt, len);
`else
    if (len === 8'hxx) chk("len_known", len, 0);
`endif
  endtask

  task automatic run_job();
    logic [7:0] len;
    len = pt_mem[0];
    push_expected();
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    chk("busy", bus.rdy, 0);
    wait_done(3 + 7 * int'(len));
    post_job(len);
  endtask

  task automatic chk_idle_outputs();
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_s_wren", bus.s_wren, 0);
    chk("rst_ct_wren", bus.ct_wren, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_wrdata", bus.s_wrdata, 0);
    chk("rst_pt_addr", bus.pt_addr, 0);
    chk("rst_ct_addr", bus.ct_addr, 0);
    chk("rst_ct_wrdata", bus.ct_wrdata, 0);
`ifdef PRGA_ENC_BYTECOUNT_EN
    chk("rst_byte_cnt", bus.byte_cnt, 0);
`endif
  endtask

  initial begin
    bool_dummy_init();
  end

  function automatic void bool_dummy_init();
    for (int a = 0; a < 256; a++) begin
      pt_mem[a] = 8'h00;
      ct_mem[a] = 8'hEE;
    end
  endfunction

  initial begin
    int found;
    #0;
    // en held during reset must not start a job
    bus.en = 1'b1;
    set_identity();
    load_s();
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs();

    // Empty message: accepted on the first edge after reset release
    pt_mem[0] = 8'h00;
    push_expected();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    chk("busy", bus.rdy, 0);
    wait_done(3);
    post_job(8'd0);
    chk("ct0_empty", ct_mem[0], 8'h00);

    // Single byte on identity S
    pt_mem[0] = 8'h01; pt_mem[1] = 8'h41;
    set_identity(); load_s();
    run_job();
    chk("ct1_single", ct_mem[1], 8'h43);

    // Two bytes: swap of S[2]/S[3] visible afterwards
    pt_mem[0] = 8'h02; pt_mem[1] = 8'h41; pt_mem[2] = 8'h42;
    set_identity(); load_s();
    run_job();
    chk("ct1_two", ct_mem[1], 8'h43);
    chk("ct2_two", ct_mem[2], 8'h47);
    chk("s2_after", s_mem[2], 8'h03);
    chk("s3_after", s_mem[3], 8'h02);

    // Encrypt then decrypt with the same key-scheduled S
    msg[0] = 8'h05; msg[1] = 8'h48; msg[2] = 8'h65; msg[3] = 8'h6C; msg[4] = 8'h6C; msg[5] = 8'h6F;
    for (int a = 0; a < 6; a++) pt_mem[a] = msg[a];
    set_ksa(); load_s();
    run_job();
    for (int a = 0; a < 6; a++) pt_mem[a] = ct_mem[a];
    load_s();
    run_job();
    for (int a = 0; a < 6; a++) chk("recover", ct_mem[a], msg[a]);

    // Maximum length: k reaches 255, i wraps
    pt_mem[0] = 8'hFF;
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom_range(0, 255));
    set_ksa(); load_s();
    run_job();
    chk("ct_last", {31'd0, ct_mem[255] !== 8'hEE}, 32'd1);

    // Reset in the middle of a job, right after the second ciphertext byte
    pt_mem[0] = 8'h05;
    set_identity(); load_s();
    push_expected();
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.ct_wren === 1'b1 && bus.ct_addr == 8'd2) begin found = 1; break; end
    end
    chk("mid_found", found, 1);
    rst_n = 1'b0;
    @(posedge clk); #1 chk_idle_outputs();
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    pt_mem[0] = 8'h01; pt_mem[1] = 8'h41;
    set_identity(); load_s();
    run_job();
    chk("ct1_after_rst", ct_mem[1], 8'h43);

    // en held high: exactly one job, next one starts on the edge rdy is first seen
    set_identity(); load_s();
    push_expected();
    push_expected();
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk); #1 chk("busy", bus.rdy, 0);
    wait_done(10);
    @(posedge clk); #1 chk("restart", bus.rdy, 0);
    bus.en = 1'b0;
    wait_done(10);
    post_job(8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
